bus_ram: RTL and testbench
==========================

# bus_ram

Parametrised single-port RAM for the shared-bus 8-bit CPU, with a memory-address register (MAR) and bus-driven RAM-in/RAM-out controls. It replaces the fixed 8-bit, 256-entry memory. It adds:
- configurable data and address widths;
- a sequential program-loader mode that streams an image into RAM through a valid/ready handshake;
- a sticky control-conflict flag.

It sits on the CPU bus beside the register file. The controller's microcode drives its control strobes.

## Interface
- DATA_W, 8, bus and memory word width
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- c_mi  in  1  load MAR from bus_in[ADDR_W-1:0]
- c_ri  in  1  write bus_in into mem[MAR]
- c_ro  in  1  drive mem[MAR] onto bus_out
- bus_in  in  DATA_W  value currently on the CPU bus
- bus_out  out  DATA_W  read data, zero when not driving
- bus_oe  out  1  bus_out is valid and owns the bus
- addr_bus  out  ADDR_W  current MAR value
- prog_mode  in  1  level; selects loader mode, CPU controls ignored while high
- prog_valid  in  1  prog_data valid
- prog_data  in  DATA_W  loader write data
- prog_ready  out  1  loader accepts a word this cycle
- prog_done  out  1  full image loaded
- err  out  1  sticky: c_ri and c_ro were asserted together

## Operation
- Clock is one domain (clk). Reset is synchronous, active-high, named reset.
- Reset values:
  - MAR=0, addr_bus=0
  - load pointer=0, loader FSM=IDLE
  - prog_ready=0, prog_done=0, err=0
  - bus_oe=0, bus_out=0
- The memory array is not cleared by reset; contents are preserved across reset.

Normal mode (FSM in IDLE):
- c_mi: MAR <= bus_in[ADDR_W-1:0] at the edge. Upper bus bits are ignored.
- c_ri: mem[MAR] <= bus_in at the edge, using the MAR value before the edge. This holds even when c_mi is asserted the same cycle.
- c_ro: bus_oe=1 and bus_out=mem[MAR], combinational (asynchronous read) in the same cycle. Otherwise bus_oe=0 and bus_out=0.
- c_ri and c_ro together: the write is suppressed, the read proceeds, and err <= 1. err stays set until reset.

Loader FSM states: IDLE, LOAD, DONE.
- IDLE -> LOAD when prog_mode=1. The load pointer <= 0 on entry.
- In LOAD, prog_ready=1.
  - On prog_valid&prog_ready: mem[ptr] <= prog_data, ptr <= ptr+1.
  - When the accepted word is at ptr=DEPTH-1: go to DONE and ptr wraps to 0.
  - Idle cycles with prog_valid=0 do not advance ptr.
- In DONE, prog_ready=0 and prog_done=1; extra prog_valid is ignored. DONE -> IDLE when prog_mode=0, and MAR <= 0 on that transition.
- LOAD with prog_mode=0 is an abort: go to IDLE, prog_done stays 0, words already written are kept, and MAR is unchanged.
- While prog_mode=1 or FSM≠IDLE:
  - c_mi, c_ri and c_ro are ignored;
  - bus_oe=0;
  - err does not update.

## Timing
- MAR update latency: 1 cycle. addr_bus shows the new value the cycle after c_mi.
- Read latency: 0 cycles, combinational from MAR and the array. A write followed by a read of the same address is visible in the next cycle.
- Loader throughput: 1 word per cycle with prog_valid held high. A full load takes DEPTH accepted cycles plus 1 entry cycle. prog_done rises the cycle after the last word is accepted.
- prog_ready is a registered state decode (high exactly in LOAD). It does not depend combinationally on prog_valid.
- Reset asserted mid-LOAD: the FSM goes to IDLE next edge, the loader outputs clear, and words already written remain.
- Simultaneous reset and any strobe: reset wins and no write occurs.

## Test plan
- Reset with DATA_W=8, ADDR_W=4: after reset, addr_bus=0, bus_oe=0, bus_out=0, prog_ready=0, prog_done=0, err=0.
- Normal write/read:
  - bus_in=8'h03 with c_mi, then bus_in=8'hA5 with c_ri, then c_ro -> bus_oe=1, bus_out=8'hA5.
  - With c_mi=0 and c_ro: addr_bus=3 and bus_out=8'hA5.
  - Then bus_in=8'hF7 with c_mi -> addr_bus=7 (upper bits ignored).
- Same-cycle c_mi+c_ri:
  - MAR=2, bus_in=8'h09, both strobes -> mem[2]=8'h09 and MAR=9.
  - Reading address 9 afterwards shows its old value.
- Conflict: MAR=5 holds 8'h11; c_ri+c_ro with bus_in=8'h22 -> bus_out=8'h11, mem[5] is still 8'h11 afterwards, and err=1 until reset.
- Full load:
  - prog_mode=1, stream values 8'h10..8'h1F with prog_valid gapped every third cycle -> prog_done rises after the 16th accept.
  - Extra prog_valid is ignored.
  - After prog_mode=0, MAR=0 and reads of addresses 0..15 return 8'h10..8'h1F.
  - c_ro asserted during load -> bus_oe=0.
- Abort/reset mid-load:
  - Drop prog_mode after 5 words -> prog_done=0, addresses 0..4 hold the new data, address 5 keeps its old data.
  - Repeat with reset after 5 words -> same contents, FSM back in IDLE.
  - A new prog_mode restarts at address 0.

Source files
------------

// File: rtl/bus_ram.sv
// -----------------------------------------------------------------------------
// bus_ram
//
// Purpose:
//   Single-port RAM that sits on the shared CPU bus. A memory-address register
//   (MAR) selects the word to read or write. Microcode strobes load the MAR,
//   write the bus into memory, or drive memory onto the bus.
//   A sequential program loader can stream a full memory image into the array
//   through a valid/ready handshake. A sticky error flag records any cycle in
//   which the controller asked to write and read the RAM together.
//
// Parameters:
//   DATA_W      bus and memory word width
//   ADDR_W      address width; the array holds 2**ADDR_W words
//
// Ports:
//   clk         single clock, all state changes on the rising edge
//   reset       synchronous, active-high
//   c_mi        load MAR from the low ADDR_W bits of bus_in
//   c_ri        write bus_in into mem[MAR]
//   c_ro        drive mem[MAR] onto bus_out (combinational read)
//   bus_in      value currently on the CPU bus
//   bus_out     read data, zero when the RAM is not driving
//   bus_oe      bus_out is valid and owns the bus
//   addr_bus    current MAR value
//   prog_mode   level; selects loader mode, CPU strobes ignored while high
//   prog_valid  prog_data holds a word to load
//   prog_data   loader write data
//   prog_ready  loader accepts a word this cycle
//   prog_done   a full image has been loaded
//   err         sticky flag, set when c_ri and c_ro were asserted together
// -----------------------------------------------------------------------------
module bus_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_mi,
  input  logic              c_ri,
  input  logic              c_ro,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic [ADDR_W-1:0] addr_bus,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loadState_e;

  loadState_e        state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              cpuActive;
  logic              loadAccept;
  logic              lastWord;
  logic              memWe;
  logic [ADDR_W-1:0] memWaddr;
  logic [DATA_W-1:0] memWdata;

  // The CPU strobes count only while the loader is fully idle and not being
  // requested. The cycle in which prog_mode first rises is already treated as
  // loader time, so a stray strobe cannot sneak in before LOAD begins.
  assign cpuActive  = (state_q == IDLE) && !prog_mode;

  // prog_ready is high for the whole of LOAD, so a handshake reduces to
  // "in LOAD and valid".
  assign loadAccept = (state_q == LOAD) && prog_valid;
  assign lastWord   = &ptr_q;

  // Loader state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Loader next-state logic. Dropping prog_mode always returns to IDLE.
  // From LOAD this is an abort, and prog_done never rises.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (prog_mode) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!prog_mode) begin
          state_d = IDLE;
        end else if (loadAccept && lastWord) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!prog_mode) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Loader and bus outputs. prog_ready and prog_done decode the registered
  // state only, so they never depend combinationally on prog_valid.
  always_comb begin
    prog_ready = (state_q == LOAD);
    prog_done  = (state_q == DONE);
    bus_oe     = cpuActive && c_ro;
    bus_out    = '0;
    if (bus_oe) begin
      bus_out = mem[mar_q];
    end
    addr_bus   = mar_q;
    err        = err_q;
  end

  // Next values for the MAR, load pointer and error flag.
  // The MAR is cleared when leaving DONE, so a freshly loaded program starts
  // executing at address 0. An aborted load leaves the MAR unchanged.
  always_comb begin
    mar_d = mar_q;
    if (cpuActive && c_mi) begin
      mar_d = bus_in[ADDR_W-1:0];
    end
    if ((state_q == DONE) && !prog_mode) begin
      mar_d = '0;
    end

    ptr_d = ptr_q;
    if ((state_q == IDLE) && prog_mode) begin
      ptr_d = '0;
    end else if (loadAccept) begin
      ptr_d = ptr_q + 1'b1;
    end

    err_d = err_q;
    if (cpuActive && c_ri && c_ro) begin
      err_d = 1'b1;
    end
  end

  // Write-port selection. Loader and CPU writes are mutually exclusive because
  // cpuActive requires IDLE. A write that collides with a read is dropped; the
  // read still proceeds and err records the conflict. The CPU write uses the
  // MAR value from before the edge, even if c_mi loads a new MAR this cycle.
  always_comb begin
    memWe    = 1'b0;
    memWaddr = mar_q;
    memWdata = bus_in;
    if (loadAccept) begin
      memWe    = 1'b1;
      memWaddr = ptr_q;
      memWdata = prog_data;
    end else if (cpuActive && c_ri && !c_ro) begin
      memWe    = 1'b1;
    end
  end

  // Control and pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mar_q <= '0;
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      mar_q <= mar_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  // Memory array. Reset does not clear it, so contents survive reset. Reset
  // does block any write in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset && memWe) begin
      mem[memWaddr] <= memWdata;
    end
  end

endmodule

// File: tb/tb_bus_ram.sv
// -----------------------------------------------------------------------------
// tb_bus_ram
//
// Self-checking bench for bus_ram (DATA_W=8, ADDR_W=4). A behavioural model
// holds the memory image, MAR, error flag and loader progress. The model is
// updated at each rising edge from the inputs of that cycle. A compare
// process checks the DUT against the model on every falling edge. Directed
// sequences add literal expectations, which also pin the model.
// -----------------------------------------------------------------------------
module tb_bus_ram;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk        = 1'b0;
  logic              reset      = 1'b1;
  logic              c_mi       = 1'b0;
  logic              c_ri       = 1'b0;
  logic              c_ro       = 1'b0;
  logic [DATA_W-1:0] bus_in     = '0;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic [ADDR_W-1:0] addr_bus;
  logic              prog_mode  = 1'b0;
  logic              prog_valid = 1'b0;
  logic [DATA_W-1:0] prog_data  = '0;
  logic              prog_ready;
  logic              prog_done;
  logic              err;

  always #5 clk = ~clk;

  bus_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .c_mi       (c_mi),
    .c_ri       (c_ri),
    .c_ro       (c_ro),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .addr_bus   (addr_bus),
    .prog_mode  (prog_mode),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_ready (prog_ready),
    .prog_done  (prog_done),
    .err        (err)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit checkEn     = 1'b0;

  // Behavioural model state.
  logic [7:0] mMem   [DEPTH];
  bit         mKnown [DEPTH];
  int         mMar     = 0;
  int         mPtr     = 0;
  bit         mLoading = 1'b0;
  bit         mDone    = 1'b0;
  bit         mErr     = 1'b0;

  bit         expOe;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit mi, input bit ri, input bit ro,
                               input logic [7:0] b, input bit pm, input bit pv,
                               input logic [7:0] pd);
    @(posedge clk);
    #1;
    reset      = rst;
    c_mi       = mi;
    c_ri       = ri;
    c_ro       = ro;
    bus_in     = b;
    prog_mode  = pm;
    prog_valid = pv;
    prog_data  = pd;
  endtask

  task automatic cpu(input bit mi, input bit ri, input bit ro, input logic [7:0] b);
    applyStimulus(1'b0, mi, ri, ro, b, 1'b0, 1'b0, 8'h00);
  endtask

  // Reads address a through the bus and compares the result with a literal.
  task automatic readExpect(input int a, input logic [7:0] exp);
    cpu(1'b1, 1'b0, 1'b0, 8'(a));
    cpu(1'b0, 1'b0, 1'b1, 8'h00);
    #2 checkOutput("read_literal", bus_out, exp);
  endtask

  // Model update at each rising edge, using the inputs of the ending cycle.
  always @(posedge clk) begin
    if (reset) begin
      mMar     = 0;
      mPtr     = 0;
      mLoading = 1'b0;
      mDone    = 1'b0;
      mErr     = 1'b0;
    end else if (mLoading) begin
      if (prog_valid) begin
        mMem[mPtr]   = prog_data;
        mKnown[mPtr] = 1'b1;
        if (prog_mode && mPtr == DEPTH - 1) begin
          mLoading = 1'b0;
          mDone    = 1'b1;
        end
        mPtr = (mPtr + 1) % DEPTH;
      end
      if (!prog_mode) mLoading = 1'b0;
    end else if (mDone) begin
      if (!prog_mode) begin
        mDone = 1'b0;
        mMar  = 0;
      end
    end else if (prog_mode) begin
      mLoading = 1'b1;
      mPtr     = 0;
    end else begin
      if (c_ri && c_ro) begin
        mErr = 1'b1;
      end else if (c_ri) begin
        mMem[mMar]   = bus_in;
        mKnown[mMar] = 1'b1;
      end
      if (c_mi) mMar = int'(bus_in) % DEPTH;
    end
  end

  // Compare process: every falling edge once the bus has been reset.
  always @(negedge clk) begin
    if (checkEn) begin
      expOe = !mLoading && !mDone && !prog_mode && c_ro;
      checkOutput("addr_bus", 32'(addr_bus), mMar);
      checkOutput("bus_oe", 32'(bus_oe), 32'(expOe));
      checkOutput("prog_ready", 32'(prog_ready), 32'(mLoading));
      checkOutput("prog_done", 32'(prog_done), 32'(mDone));
      checkOutput("err", 32'(err), 32'(mErr));
      if (!expOe) begin
        checkOutput("bus_out_idle", 32'(bus_out), 0);
      end else if (mKnown[mMar]) begin
        checkOutput("bus_out", 32'(bus_out), 32'(mMem[mMar]));
      end
    end
  end

  bit         v;
  int         idx;
  bit         rpm;

  initial begin
    for (int a = 0; a < DEPTH; a++) mKnown[a] = 1'b0;

    // Reset, with a write strobe present: reset must win.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1 checkEn = 1'b1;
    cpu(1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    checkOutput("rst_addr", 32'(addr_bus), 0);
    checkOutput("rst_oe", 32'(bus_oe), 0);
    checkOutput("rst_out", 32'(bus_out), 0);
    checkOutput("rst_ready", 32'(prog_ready), 0);
    checkOutput("rst_done", 32'(prog_done), 0);
    checkOutput("rst_err", 32'(err), 0);

    // Give every address a known value through the CPU path.
    for (int a = 0; a < DEPTH; a++) begin
      cpu(1'b1, 1'b0, 1'b0, 8'(a));
      cpu(1'b0, 1'b1, 1'b0, 8'($urandom));
    end

    // Basic write and read.
    cpu(1'b1, 1'b0, 1'b0, 8'h03);
    cpu(1'b0, 1'b1, 1'b0, 8'hA5);
    cpu(1'b0, 1'b0, 1'b1, 8'h00);
    #2;
    checkOutput("wr_rd_oe", 32'(bus_oe), 1);
    checkOutput("wr_rd_out", 32'(bus_out), 32'h A5);
    checkOutput("wr_rd_addr", 32'(addr_bus), 3);
    cpu(1'b1, 1'b0, 1'b0, 8'hF7);
    cpu(1'b0, 1'b0, 1'b0, 8'h00);
    #2 checkOutput("mar_upper_ignored", 32'(addr_bus), 7);

    // c_mi and c_ri in the same cycle: write goes to the old MAR.
    cpu(1'b1, 1'b0, 1'b0, 8'h02);
    cpu(1'b1, 1'b1, 1'b0, 8'h09);
    cpu(1'b0, 1'b0, 1'b0, 8'h00);
    #2 checkOutput("mi_ri_mar", 32'(addr_bus), 9);
    cpu(1'b0, 1'b0, 1'b1, 8'h00);
    readExpect(2, 8'h09);

    // Conflict: the read proceeds, the write is dropped, err is sticky.
    cpu(1'b1, 1'b0, 1'b0, 8'h05);
    cpu(1'b0, 1'b1, 1'b0, 8'h11);
    cpu(1'b0, 1'b1, 1'b1, 8'h22);
    #2 checkOutput("conflict_read", 32'(bus_out), 32'h11);
    cpu(1'b0, 1'b0, 1'b1, 8'h00);
    #2;
    checkOutput("conflict_kept", 32'(bus_out), 32'h11);
    checkOutput("conflict_err", 32'(err), 1);

    // Random CPU traffic.
    for (int i = 0; i < 200; i++) begin
      cpu(($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 2) == 0, 8'($urandom));
    end

    // Full load with prog_valid gapped every third cycle and c_ro held high.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00);
    #2;
    checkOutput("load_entry_ready", 32'(prog_ready), 0);
    checkOutput("load_entry_oe", 32'(bus_oe), 0);
    idx = 0;
    for (int k = 0; k < 60 && idx < DEPTH; k++) begin
      v = (k % 3) != 2;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h0F, 1'b1, v, 8'(16 + idx));
      if (k == 0) begin
        #2;
        checkOutput("load_ready", 32'(prog_ready), 1);
        checkOutput("load_oe_blocked", 32'(bus_oe), 0);
      end
      if (v) idx++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    #2;
    checkOutput("load_done", 32'(prog_done), 1);
    checkOutput("load_done_ready", 32'(prog_ready), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hEE);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    cpu(1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    checkOutput("load_mar_zero", 32'(addr_bus), 0);
    checkOutput("load_done_clear", 32'(prog_done), 0);
    for (int a = 0; a < DEPTH; a++) readExpect(a, 8'(16 + a));

    // Abort after five words.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h40 + i));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    cpu(1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    checkOutput("abort_done", 32'(prog_done), 0);
    checkOutput("abort_ready", 32'(prog_ready), 0);
    for (int a = 0; a < 5; a++) readExpect(a, 8'(8'h40 + a));
    readExpect(5, 8'h15);

    // Reset after five words.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h60 + i));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    cpu(1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    checkOutput("rstload_ready", 32'(prog_ready), 0);
    checkOutput("rstload_done", 32'(prog_done), 0);
    checkOutput("rstload_err", 32'(err), 0);
    checkOutput("rstload_addr", 32'(addr_bus), 0);
    for (int a = 0; a < 5; a++) readExpect(a, 8'(8'h60 + a));
    readExpect(5, 8'h15);

    // A new load restarts at address 0.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h77);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    readExpect(0, 8'h77);
    readExpect(1, 8'h61);

    // Reset together with strobes: no write, MAR cleared.
    cpu(1'b1, 1'b0, 1'b0, 8'h06);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'hAB, 1'b0, 1'b0, 8'h00);
    cpu(1'b0, 1'b0, 1'b0, 8'h00);
    #2 checkOutput("rst_strobe_addr", 32'(addr_bus), 0);
    readExpect(6, 8'h16);

    // Random mixed traffic. prog_valid is only driven while prog_mode is high.
    rpm = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 25) == 0) rpm = !rpm;
      applyStimulus(($urandom % 150) == 0, ($urandom % 3) == 0, ($urandom % 4) == 0,
                    ($urandom % 2) == 0, 8'($urandom), rpm,
                    rpm && (($urandom % 3) != 0), 8'($urandom));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
